// File: rtl/winograd_ewmm_accumulator.sv
// winograd_ewmm_accumulator: element-wise U(.)V multiply-accumulate over channels for one Winograd F(4x4,3x3) tile
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   per-channel U/V tile pair handshake; in_last marks the final channel
//   u_tile, v_tile      6x6 transformed kernel and input tiles
//   m_valid/out_ready   accumulated tile handshake; m_tile held stable while m_valid=1
module winograd_ewmm_accumulator #(
    parameter int DATA_W = 16,
    parameter int TILE   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] u_tile [TILE][TILE],
    input  logic [DATA_W-1:0] v_tile [TILE][TILE],
    output logic              m_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] m_tile [TILE][TILE]
);
    localparam int RW = $clog2(TILE);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t            state, next;
    logic [RW-1:0]     row;
    logic              first_ch, last_q;
    logic [DATA_W-1:0] u_q [TILE][TILE];
    logic [DATA_W-1:0] v_q [TILE][TILE];
    logic [DATA_W-1:0] acc [TILE][TILE];
    logic              row_end;

    assign row_end = row == RW'(TILE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = in_valid ? S_MAC : S_IDLE;
            S_MAC:   next = row_end ? (last_q ? S_DONE : S_IDLE) : S_MAC;
            S_DONE:  next = out_ready ? S_IDLE : S_DONE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == S_IDLE;
        m_valid  = state == S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= '0;
            first_ch <= 1'b1;
            last_q   <= 1'b0;
            for (int i = 0; i < TILE; i++)
                for (int j = 0; j < TILE; j++) begin
                    u_q[i][j] <= '0;
                    v_q[i][j] <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    u_q    <= u_tile;
                    v_q    <= v_tile;
                    last_q <= in_last;
                    row    <= '0;
                end
                S_MAC: begin
                    // first channel of a tile overwrites instead of accumulating, so old sums never leak
                    for (int j = 0; j < TILE; j++)
                        acc[row][j] <= (first_ch ? '0 : acc[row][j]) + u_q[row][j] * v_q[row][j];
                    row <= row + 1'b1;
                    if (row_end) first_ch <= 1'b0;
                end
                S_DONE: if (out_ready) first_ch <= 1'b1;
                default: ;
            endcase
        end
    end

    assign m_tile = acc;
endmodule

// File: tb/tb_winograd_ewmm_accumulator.sv
// tb_winograd_ewmm_accumulator: directed self-checking bench for winograd_ewmm_accumulator
module tb_winograd_ewmm_accumulator;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic        in_last = 0;
    logic [15:0] u_tile [6][6];
    logic [15:0] v_tile [6][6];
    logic        m_valid;
    logic        out_ready = 0;
    logic [15:0] m_tile [6][6];
    int          checks = 0;
    int          errors = 0;

    winograd_ewmm_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .u_tile(u_tile), .v_tile(v_tile), .m_valid(m_valid), .out_ready(out_ready), .m_tile(m_tile)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input logic [15:0] val, input bit pat);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                chk($sformatf("%s[%0d][%0d]", tag, i, j), 32'(m_tile[i][j]), pat ? 32'(6 * i + j) : 32'(val));
    endtask

    task automatic set_uv(input logic [15:0] u, input logic [15:0] v, input bit pat);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                u_tile[i][j] = u;
                v_tile[i][j] = pat ? 16'(6 * i + j) : v;
            end
    endtask

    // Called at a negedge in S_IDLE; returns at the negedge after the 6th MAC edge.
    // glitch pokes new data and in_valid during MAC to confirm it is ignored.
    task automatic send(input string tag, input bit last, input bit glitch);
        chk({tag, "_ready_pre"}, 32'(in_ready), 32'd1);
        in_valid = 1;
        in_last  = last;
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_ready_mac%0d", tag, k), 32'(in_ready), 32'd0);
            chk($sformatf("%s_valid_mac%0d", tag, k), 32'(m_valid), 32'd0);
            if (glitch && k == 2) begin
                set_uv(16'd5, 16'd5, 0);
                in_valid = 1;
                in_last  = 1;
            end
            if (glitch && k == 3) begin
                in_valid = 0;
                in_last  = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_tile(input string tag);
        chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        chk({tag, "_inready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_mvalid_rel"}, 32'(m_valid), 32'd0);
        chk({tag, "_inready_rel"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        set_uv(16'd0, 16'd0, 0);
        #12;
        chk("rst_inready", 32'(in_ready), 32'd1);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk_tile("rst_tile", 16'd0, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // T1 single channel, V ramp
        set_uv(16'd1, 16'd0, 1);
        send("t1", 1, 0);
        chk_tile("t1_tile", 16'd0, 1);
        release_tile("t1");

        // T2 three channels of 2*3
        set_uv(16'd2, 16'd3, 0);
        send("t2a", 0, 0);
        chk("t2a_ready", 32'(in_ready), 32'd1);
        send("t2b", 0, 0);
        chk("t2b_ready", 32'(in_ready), 32'd1);
        send("t2c", 1, 0);
        chk_tile("t2_tile", 16'd18, 0);
        release_tile("t2");

        // T3 wrap and sign
        set_uv(16'h0100, 16'h0100, 0);
        send("t3a", 1, 0);
        chk_tile("t3a_tile", 16'h0000, 0);
        release_tile("t3a");
        set_uv(16'hFFFF, 16'h0005, 0);
        send("t3b", 1, 0);
        chk_tile("t3b_tile", 16'hFFFB, 0);
        release_tile("t3b");
        set_uv(16'h7FFF, 16'h0001, 0);
        send("t3c1", 0, 0);
        send("t3c2", 1, 0);
        chk_tile("t3c_tile", 16'hFFFE, 0);

        // T4 backpressure held in S_DONE
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t4_mvalid%0d", k), 32'(m_valid), 32'd1);
            chk($sformatf("t4_inready%0d", k), 32'(in_ready), 32'd0);
            chk_tile($sformatf("t4_hold%0d", k), 16'hFFFE, 0);
        end
        release_tile("t4");
        set_uv(16'd1, 16'd1, 0);
        send("t4n", 1, 0);
        chk_tile("t4n_tile", 16'd1, 0);
        release_tile("t4n");

        // T5 reset after 3 MAC edges
        set_uv(16'd9, 16'd9, 0);
        in_valid = 1;
        in_last  = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last  = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("t5_inready", 32'(in_ready), 32'd1);
        chk("t5_mvalid", 32'(m_valid), 32'd0);
        chk_tile("t5_tile", 16'd0, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        set_uv(16'd1, 16'd7, 0);
        send("t5n", 1, 0);
        chk_tile("t5n_tile", 16'd7, 0);
        release_tile("t5n");

        // T6 inputs changed and in_valid pulsed during MAC are ignored
        set_uv(16'd2, 16'd3, 0);
        send("t6", 1, 1);
        chk_tile("t6_tile", 16'd6, 0);
        release_tile("t6");
        @(negedge clk);
        chk("t6_idle_mvalid", 32'(m_valid), 32'd0);
        chk("t6_idle_inready", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
